// File: rtl/ws2812_frame_tx.sv
// ws2812_frame_tx
// Serialises the four BCD clock digits onto a WS2812B LED chain: one pixel
// per digit bit (16 pixels), each pixel is a 24-bit GRB word sent MSB first.
// Digits are snapshotted when a start request is accepted. After the 384 data
// bits, the line is held low for the latch time, and then done pulses.
//
// Handshake: start is a single-cycle request. It is accepted only while the
// FSM is IDLE. While busy is high, start is dropped (not queued). done pulses
// for one cycle, on the same cycle that busy falls.
//
// Ports:
//   hwclk       system clock
//   rst_n       synchronous active-low reset
//   start       frame request
//   dm0/dm1     minutes units/tens digit
//   dh0/dh1     hours units/tens digit
//   dout        WS2812 data line (registered)
//   busy        frame (bits + latch) in progress (registered)
//   done        one-cycle completion pulse (registered)
module ws2812_frame_tx #(
    parameter int          BIT_CYCLES   = 15,
    parameter int          T0H_CYCLES   = 4,
    parameter int          T1H_CYCLES   = 9,
    parameter int          LATCH_CYCLES = 3600,
    parameter logic [23:0] ON_COLOR     = 24'h101010,
    parameter logic [23:0] OFF_COLOR    = 24'h000000
) (
    input  logic       hwclk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] dm0,
    input  logic [3:0] dm1,
    input  logic [3:0] dh0,
    input  logic [3:0] dh1,
    output logic       dout,
    output logic       busy,
    output logic       done
);

    // One shared cycle counter serves both the bit timing and the latch
    // hold, so it is sized for the larger of the two periods.
    localparam int CNT_MAX = (LATCH_CYCLES > BIT_CYCLES) ? LATCH_CYCLES : BIT_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BIT   = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     snap_q, snap_d;
    logic [3:0]      pixel_q, pixel_d;
    logic [4:0]      bit_q, bit_d;
    logic [CW-1:0]   cycle_q, cycle_d;
    logic            dout_q, dout_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [23:0]     colour_d;
    logic            cbit_d;

    always_ff @(posedge hwclk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            snap_q  <= '0;
            pixel_q <= '0;
            bit_q   <= '0;
            cycle_q <= '0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            pixel_q <= pixel_d;
            bit_q   <= bit_d;
            cycle_q <= cycle_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        pixel_d  = pixel_q;
        bit_d    = bit_q;
        cycle_d  = cycle_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dout_d   = 1'b0;
        colour_d = OFF_COLOR;
        cbit_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = {dh1, dh0, dm1, dm0};
                    pixel_d = 4'd0;
                    bit_d   = 5'd23;
                    cycle_d = '0;
                    busy_d  = 1'b1;
                    state_d = BIT;
                end
            end
            BIT: begin
                if (cycle_q == CW'(BIT_CYCLES - 1)) begin
                    cycle_d = '0;
                    if (bit_q == 5'd0) begin
                        bit_d = 5'd23;
                        if (pixel_q == 4'd15) begin
                            state_d = LATCH;
                        end else begin
                            pixel_d = pixel_q + 4'd1;
                        end
                    end else begin
                        bit_d = bit_q - 5'd1;
                    end
                end else begin
                    cycle_d = cycle_q + CW'(1);
                end
            end
            LATCH: begin
                if (cycle_q == CW'(LATCH_CYCLES - 1)) begin
                    cycle_d = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cycle_d = cycle_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // dout is decoded from the next-state counters so the registered pin
        // lines up with them: the first high appears the cycle after start.
        colour_d = snap_d[pixel_d] ? ON_COLOR : OFF_COLOR;
        cbit_d   = colour_d[bit_d];
        if (state_d == BIT) begin
            dout_d = cbit_d ? (cycle_d < CW'(T1H_CYCLES)) : (cycle_d < CW'(T0H_CYCLES));
        end
    end

    assign dout = dout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
